// File: rtl/data_ram_ctrl_if.sv
// Request/response bundle between the MEM stage and the data-RAM controller.
// The master side is the pipeline, the slave side is the controller.
interface data_ram_ctrl_if;
  logic        ce_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [3:0]  sel_i;
  logic [31:0] data_i;
  logic        flush_i;
  logic [31:0] data_o;
  logic        stall_req_o;
  logic        done_o;

  modport master (
    output ce_i, we_i, addr_i, sel_i, data_i, flush_i,
    input  data_o, stall_req_o, done_o
  );

  modport slave (
    input  ce_i, we_i, addr_i, sel_i, data_i, flush_i,
    output data_o, stall_req_o, done_o
  );
endinterface

// File: rtl/data_ram_ctrl.sv
// Data-memory controller: word RAM with byte-lane writes and a fixed access
// latency. It stalls the pipeline while an access is in flight.
module data_ram_ctrl #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic          clk,
  input  logic          rst,
  data_ram_ctrl_if.slave bus
);
  localparam int         DEPTH  = 1 << DEPTH_LOG2;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                  state_reg, state_next;
  logic [3:0]              cnt_reg;
  logic                    we_reg;
  logic [DEPTH_LOG2-1:0]   word_reg;
  logic [3:0]              sel_reg;
  logic [31:0]             data_reg;
  logic                    accept;
  logic                    commit;
  wire  [31:0]             rd_word;
  logic                    unused_addr;

  // Byte offset and bits above the RAM size are dropped, so accesses wrap.
  assign unused_addr = ^{bus.addr_i[1:0], bus.addr_i[31:DEPTH_LOG2+2]};

  assign accept = (state_reg == IDLE) && bus.ce_i && !bus.flush_i;
  // Flush and reset both beat the commit on the final BUSY edge.
  assign commit = (state_reg == BUSY) && (cnt_reg == 4'd0) && !bus.flush_i && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      we_reg    <= 1'b0;
      word_reg  <= '0;
      sel_reg   <= 4'd0;
      data_reg  <= 32'd0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        we_reg   <= bus.we_i;
        word_reg <= bus.addr_i[DEPTH_LOG2+1:2];
        sel_reg  <= bus.sel_i;
        data_reg <= bus.data_i;
        cnt_reg  <= LAT_M1;
      end else if (state_reg == BUSY && cnt_reg != 4'd0) begin
        cnt_reg <= cnt_reg - 4'd1;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = BUSY;
      BUSY: begin
        if (bus.flush_i)           state_next = IDLE;
        else if (cnt_reg == 4'd0)  state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.stall_req_o = 1'b0;
    bus.done_o      = 1'b0;
    case (state_reg)
      IDLE:    bus.stall_req_o = accept;
      BUSY:    bus.stall_req_o = 1'b1;
      DONE:    bus.done_o      = 1'b1;
      default: ;
    endcase
  end

  // One byte-wide RAM per lane gives clean byte-enable inference.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] ram [DEPTH];
    logic [7:0] rd_reg;

    always_ff @(posedge clk) begin
      if (commit && we_reg && sel_reg[gi])
        ram[word_reg] <= data_reg[8*gi +: 8];
    end

    always_ff @(posedge clk) begin
      if (rst)
        rd_reg <= 8'h00;
      else if (commit && !we_reg)
        rd_reg <= sel_reg[gi] ? ram[word_reg] : 8'h00;
    end

    assign rd_word[8*gi +: 8] = rd_reg;
  end

  assign bus.data_o = rd_word;
endmodule

// File: tb/tb_data_ram_ctrl.sv
// Directed bench for data_ram_ctrl: read results are queued when each read is
// issued and compared when done_o pulses.
module tb_data_ram_ctrl;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   passes = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  data_ram_ctrl_if bus ();

  data_ram_ctrl #(.DEPTH_LOG2(10), .LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One full access; for reads, exp is queued now and checked at done_o.
  // tamper scrambles every request input once the access is in BUSY.
  task automatic access(input bit we, input logic [31:0] addr, input logic [3:0] sel,
                        input logic [31:0] data, input logic [31:0] exp, input bit tamper);
    int stall_cnt = 0;
    int cyc = 0;
    bit seen = 1'b0;
    if (!we) exp_q.push_back(exp);
    bus.ce_i   = 1'b1;
    bus.we_i   = we;
    bus.addr_i = addr;
    bus.sel_i  = sel;
    bus.data_i = data;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      cyc++;
      if (bus.done_o) begin
        seen = 1'b1;
      end else begin
        if (bus.stall_req_o) stall_cnt++;
        if (tamper && cyc == 2) begin
          bus.ce_i   = 1'b0;
          bus.we_i   = ~we;
          bus.addr_i = addr ^ 32'h40;
          bus.sel_i  = ~sel;
          bus.data_i = ~data;
        end
      end
    end
    check("done_seen", 32'(seen), 32'd1);
    check("stall_cycles", stall_cnt, LAT + 1);
    check("access_cycles", cyc, LAT + 2);
    if (!we && exp_q.size() > 0) check("rdata", bus.data_o, exp_q.pop_front());
    $display("%s addr=%h sel=%b data=%h -> data_o=%h cycles=%0d stall=%0d",
             we ? "WR" : "RD", addr, sel, data, bus.data_o, cyc, stall_cnt);
    @(posedge clk);
    #1;
    bus.ce_i = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    bus.ce_i    = 1'b0;
    bus.we_i    = 1'b0;
    bus.addr_i  = 32'd0;
    bus.sel_i   = 4'd0;
    bus.data_i  = 32'd0;
    bus.flush_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_data_o", bus.data_o, 32'd0);
    check("rst_stall", 32'(bus.stall_req_o), 32'd0);
    check("rst_done", 32'(bus.done_o), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // T1: full-word write and read back
    access(1'b1, 32'h10, 4'b1111, 32'hDEADBEEF, 32'h0, 1'b0);
    access(1'b0, 32'h10, 4'b1111, 32'h0, 32'hDEADBEEF, 1'b0);
    // T2: single-lane write, partial-lane read
    access(1'b1, 32'h10, 4'b0100, 32'h00AA0000, 32'h0, 1'b0);
    access(1'b0, 32'h10, 4'b1111, 32'h0, 32'hDEAABEEF, 1'b0);
    access(1'b0, 32'h10, 4'b0011, 32'h0, 32'h0000BEEF, 1'b0);
    // sel=0: write is a no-op, data_o keeps the last read, read yields 0
    access(1'b1, 32'h10, 4'b0000, 32'hFFFFFFFF, 32'h0, 1'b0);
    check("hold_after_write", bus.data_o, 32'h0000BEEF);
    access(1'b0, 32'h10, 4'b1111, 32'h0, 32'hDEAABEEF, 1'b0);
    access(1'b0, 32'h10, 4'b0000, 32'h0, 32'h00000000, 1'b0);
    // T3: address wrap and ignored byte offset
    access(1'b1, 32'h1000, 4'b1111, 32'h12345678, 32'h0, 1'b0);
    access(1'b0, 32'h0000, 4'b1111, 32'h0, 32'h12345678, 1'b0);
    access(1'b0, 32'h0003, 4'b1111, 32'h0, 32'h12345678, 1'b0);
    // T4: inputs changed during BUSY leave the latched access intact
    access(1'b1, 32'h44, 4'b1111, 32'hA5A5A5A5, 32'h0, 1'b1);
    access(1'b0, 32'h44, 4'b1111, 32'h0, 32'hA5A5A5A5, 1'b0);
    access(1'b0, 32'h10, 4'b1111, 32'h0, 32'hDEAABEEF, 1'b1);

    // Flush in IDLE suppresses acceptance
    bus.ce_i    = 1'b1;
    bus.we_i    = 1'b1;
    bus.addr_i  = 32'h44;
    bus.sel_i   = 4'b1111;
    bus.data_i  = 32'h0;
    bus.flush_i = 1'b1;
    @(negedge clk);
    check("idle_flush_stall", 32'(bus.stall_req_o), 32'd0);
    @(posedge clk);
    #1;
    bus.ce_i    = 1'b0;
    bus.flush_i = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("idle_flush_done", 32'(bus.done_o), 32'd0);
    end

    // T5: flush in the last BUSY cycle of a write aborts it
    @(posedge clk);
    #1;
    bus.ce_i   = 1'b1;
    bus.we_i   = 1'b1;
    bus.addr_i = 32'h44;
    bus.sel_i  = 4'b1111;
    bus.data_i = 32'h00000000;
    repeat (LAT) begin
      @(posedge clk);
      #1;
    end
    bus.ce_i    = 1'b0;
    bus.flush_i = 1'b1;
    @(negedge clk);
    check("flush_busy_stall", 32'(bus.stall_req_o), 32'd1);
    @(posedge clk);
    #1;
    bus.flush_i = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("flush_no_done", 32'(bus.done_o), 32'd0);
      check("flush_idle_stall", 32'(bus.stall_req_o), 32'd0);
    end
    @(posedge clk);
    #1;
    access(1'b0, 32'h44, 4'b1111, 32'h0, 32'hA5A5A5A5, 1'b0);

    // T6: reset in the commit cycle drops the pending write
    access(1'b1, 32'h30, 4'b1111, 32'h11111111, 32'h0, 1'b0);
    bus.ce_i   = 1'b1;
    bus.we_i   = 1'b1;
    bus.addr_i = 32'h30;
    bus.sel_i  = 4'b1111;
    bus.data_i = 32'hCAFEF00D;
    repeat (LAT) begin
      @(posedge clk);
      #1;
    end
    bus.ce_i = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    check("pre_rst_data_o", bus.data_o, 32'hA5A5A5A5);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_data_o", bus.data_o, 32'd0);
    check("midrst_stall", 32'(bus.stall_req_o), 32'd0);
    check("midrst_done", 32'(bus.done_o), 32'd0);
    @(posedge clk);
    #1;
    access(1'b0, 32'h30, 4'b1111, 32'h0, 32'h11111111, 1'b0);

    check("queue_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
